fuzz_mem_model: RTL

FUZZ_MEM_MODEL -- requirements
Module: fuzz_mem_model

---
 rtl/fuzz_mem_model.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fuzz_mem_model.sv
// Behavioural memory model with randomly filled code and data stores, RISC-V AMOs, a cache-flush stall and a timer interrupt.
// Latency: LATENCY cycles from request acceptance to a one-cycle ready pulse; the store is read and updated on the ready edge.
// Backpressure: each port takes one request at a time, only in IDLE; requests seen while busy are dropped, never queued.
//
// Ports: clk/rst (async active-high); code_addr_i/code_req_i -> code_o/code_ready_o (instruction fetch);
//        data_i/data_addr_i/data_rw_i/data_byte_enable_i/data_req_i/data_is_amo_i/data_amo_type_i -> data_o/data_ready_o;
//        cache_flush_i -> stall_o; tmr_irq_o periodic pulse; init_pc_addr_o/data_addr_ext_o/ext_irq_o/sft_irq_o tied low.
module fuzz_mem_model #(
    parameter int          XLEN       = 32,
    parameter int          LATENCY    = 1,
    parameter int          UNIFIED    = 0,
    parameter int          TMR_PERIOD = 0,
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [63:0] RNG_SEED   = 64'h9E37_79B9_7F4A_7C15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   code_addr_i,
    input  logic              code_req_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic              data_rw_i,
    input  logic [XLEN/8-1:0] data_byte_enable_i,
    input  logic              data_req_i,
    input  logic              data_is_amo_i,
    input  logic [4:0]        data_amo_type_i,
    input  logic              cache_flush_i,
    output logic [XLEN-1:0]   code_o,
    output logic              code_ready_o,
    output logic [XLEN-1:0]   data_o,
    output logic              data_ready_o,
    output logic              stall_o,
    output logic [XLEN-1:0]   init_pc_addr_o,
    output logic              data_addr_ext_o,
    output logic              ext_irq_o,
    output logic              tmr_irq_o,
    output logic              sft_irq_o
);

    localparam int         BE_W     = XLEN / 8;
    localparam int         OFF      = $clog2(BE_W);
    localparam int         SW       = DEPTH_LOG2 + 1;   // slot index; top bit selects the code half
    localparam logic       CODE_HI  = (UNIFIED == 0);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] TMR_LAST = 32'(TMR_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_t;

    // Store plus a per-word "touched" flag. Neither is reset so contents survive rst.
    logic [XLEN-1:0] mem [2**SW];
    logic [2**SW-1:0] vld;

    state_t          c_state, c_next, d_state, d_next;
    logic            c_accept, c_done, d_accept, d_done, f_accept;
    logic [3:0]      c_cnt, d_cnt;
    logic [SW-1:0]   c_slot, d_slot;
    logic [XLEN-1:0] d_wdat;
    logic [BE_W-1:0] d_be;
    logic            d_rw, d_amo;
    logic [4:0]      d_amo_type;
    logic [XLEN-1:0] c_old, d_old, d_new, rng, rng_nx;
    logic            d_upd, c_we, d_we;
    logic [31:0]     tmr_cnt;
    logic            unused_addr_bits;

    // Fill value for an untouched code word: addi rd, x0, imm with rd/imm taken
    // from the slot, so every fetch decodes as a legal instruction.
    function automatic logic [XLEN-1:0] instruction_generator(input logic [SW-1:0] slot);
        logic [31:0] insn;
        insn = {12'(slot), 5'd0, 3'b000, 5'(slot), 7'b0010011};
        return XLEN'(insn);
    endfunction

    assign unused_addr_bits = ^{code_addr_i, data_addr_i};

    // ---------------- FSMs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_state <= ST_IDLE;
            d_state <= ST_IDLE;
        end else begin
            c_state <= c_next;
            d_state <= d_next;
        end
    end

    always_comb begin
        c_next   = c_state;
        c_accept = 1'b0;
        c_done   = 1'b0;
        case (c_state)
            ST_IDLE: if (code_req_i) begin
                c_next   = ST_WAIT;
                c_accept = 1'b1;
            end
            ST_WAIT: if (c_cnt == 4'd0) begin
                c_next = ST_IDLE;
                c_done = 1'b1;
            end
            default: c_next = ST_IDLE;
        endcase
    end

    // A data request wins over a flush arriving in the same IDLE cycle.
    always_comb begin
        d_next   = d_state;
        d_accept = 1'b0;
        f_accept = 1'b0;
        d_done   = 1'b0;
        case (d_state)
            ST_IDLE: begin
                if (data_req_i) begin
                    d_next   = ST_WAIT;
                    d_accept = 1'b1;
                end else if (cache_flush_i) begin
                    d_next   = ST_FLUSH;
                    f_accept = 1'b1;
                end
            end
            ST_WAIT: if (d_cnt == 4'd0) begin
                d_next = ST_IDLE;
                d_done = 1'b1;
            end
            ST_FLUSH: if (d_cnt == 4'd0) d_next = ST_IDLE;
            default: d_next = ST_IDLE;
        endcase
    end

    // ---------------- store access ----------------
    // Code reads here see the pre-edge contents, so a same-edge data write in
    // the unified store is not visible to the fetch completing on that edge.
    assign c_old = vld[c_slot] ? mem[c_slot] : instruction_generator(c_slot);
    assign d_old = vld[d_slot] ? mem[d_slot] : rng;

    always_comb begin
        d_new = d_old;
        d_upd = 1'b0;
        if (d_amo) begin
            d_upd = 1'b1;
            case (d_amo_type)
                5'b00000: d_new = d_old + d_wdat;
                5'b00001: d_new = d_wdat;
                5'b00100: d_new = d_old ^ d_wdat;
                5'b01100: d_new = d_old & d_wdat;
                5'b01000: d_new = d_old | d_wdat;
                5'b10000: d_new = ($signed(d_old) < $signed(d_wdat)) ? d_old : d_wdat;
                5'b10100: d_new = ($signed(d_old) > $signed(d_wdat)) ? d_old : d_wdat;
                5'b11000: d_new = (d_old < d_wdat) ? d_old : d_wdat;
                5'b11100: d_new = (d_old > d_wdat) ? d_old : d_wdat;
                default:  d_upd = 1'b0;
            endcase
        end else if (d_rw) begin
            d_upd = 1'b1;
            for (int b = 0; b < BE_W; b++)
                if (d_be[b]) d_new[8*b +: 8] = d_wdat[8*b +: 8];
        end
    end

    // Untouched words are written back with their fill value so it persists.
    assign c_we = c_done && !vld[c_slot];
    assign d_we = d_done && (d_upd || !vld[d_slot]);

    // Data write is last so it wins when both ports hit the same unified slot.
    always_ff @(posedge clk) begin
        if (c_we) begin
            mem[c_slot] <= c_old;
            vld[c_slot] <= 1'b1;
        end
        if (d_we) begin
            mem[d_slot] <= d_upd ? d_new : d_old;
            vld[d_slot] <= 1'b1;
        end
    end

    // xorshift source for untouched data words; advances every cycle.
    always_comb begin
        rng_nx = rng ^ (rng << 13);
        rng_nx = rng_nx ^ (rng_nx >> 7);
        rng_nx = rng_nx ^ (rng_nx << 17);
    end

    // ---------------- capture, counters, outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_cnt        <= '0;
            c_slot       <= '0;
            d_cnt        <= '0;
            d_slot       <= '0;
            d_wdat       <= '0;
            d_be         <= '0;
            d_rw         <= 1'b0;
            d_amo        <= 1'b0;
            d_amo_type   <= '0;
            code_o       <= '0;
            code_ready_o <= 1'b0;
            data_o       <= '0;
            data_ready_o <= 1'b0;
            rng          <= XLEN'(RNG_SEED);
        end else begin
            code_ready_o <= c_done;
            data_ready_o <= d_done;
            rng          <= rng_nx;

            if (c_accept) begin
                c_slot <= {CODE_HI, code_addr_i[OFF +: DEPTH_LOG2]};
                c_cnt  <= LAT_INIT;
            end else if (c_state == ST_WAIT && c_cnt != 4'd0) begin
                c_cnt <= c_cnt - 4'd1;
            end
            if (c_done) code_o <= c_old;

            if (d_accept) begin
                d_slot     <= {1'b0, data_addr_i[OFF +: DEPTH_LOG2]};
                d_wdat     <= data_i;
                d_be       <= data_byte_enable_i;
                d_rw       <= data_rw_i;
                d_amo      <= data_is_amo_i;
                d_amo_type <= data_amo_type_i;
            end
            if (d_accept || f_accept) begin
                d_cnt <= LAT_INIT;
            end else if (d_state != ST_IDLE && d_cnt != 4'd0) begin
                d_cnt <= d_cnt - 4'd1;
            end
            // Plain writes leave data_o alone; reads and AMOs return the old word.
            if (d_done && (d_amo || !d_rw)) data_o <= d_old;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_cnt   <= '0;
            tmr_irq_o <= 1'b0;
        end else if (TMR_PERIOD == 0) begin
            tmr_cnt   <= '0;
            tmr_irq_o <= 1'b0;
        end else if (tmr_cnt == TMR_LAST) begin
            tmr_cnt   <= '0;
            tmr_irq_o <= 1'b1;
        end else begin
            tmr_cnt   <= tmr_cnt + 32'd1;
            tmr_irq_o <= 1'b0;
        end
    end

    assign stall_o         = (d_state != ST_IDLE);
    assign init_pc_addr_o  = '0;
    assign data_addr_ext_o = 1'b0;
    assign ext_irq_o       = 1'b0;
    assign sft_irq_o       = 1'b0;

endmodule
